mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 119 +++++++++++
 tb/tb_mem_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port arbiter (CPU and debug/loader) in front of a single-port RAM with registered reads.
// Round-robin or fixed CPU priority, plus an exclusive debug lock mode.
module mem_arbiter #(
  parameter bit RR_EN = 1'b1
) (
  input  logic        test_clk,
  input  logic        test_rst_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [14:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic        cpu_gnt,
  output logic        cpu_rvalid,
  output logic [15:0] cpu_rdata,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [14:0] dbg_addr,
  input  logic [15:0] dbg_wdata,
  input  logic        dbg_lock,
  output logic        dbg_gnt,
  output logic        dbg_rvalid,
  output logic [15:0] dbg_rdata,
  output logic [14:0] mem_test_addr,
  output logic        mem_test_we,
  output logic [15:0] mem_test_wdata,
  input  logic [15:0] mem_test_rdata
);

  typedef enum logic [0:0] {StArb, StLock} state_e;

  state_e      state_q, state_d;
  logic        ptr_dbg_q, ptr_dbg_d;  // 1: debug port wins the next tie
  logic        cpu_rd_q, dbg_rd_q;
  logic [15:0] cpu_hold_q, dbg_hold_q;

  // State register
  always_ff @(posedge test_clk or negedge test_rst_n) begin
    if (!test_rst_n) begin
      state_q <= StArb;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StArb:   if (dbg_gnt && dbg_lock) state_d = StLock;
      StLock:  if (!dbg_lock) state_d = StArb;
      default: state_d = StArb;
    endcase
  end

  // Grant outputs; nothing is granted while reset is asserted
  always_comb begin
    cpu_gnt = 1'b0;
    dbg_gnt = 1'b0;
    if (test_rst_n) begin
      unique case (state_q)
        StArb: begin
          if (cpu_req && dbg_req) begin
            if (RR_EN && ptr_dbg_q) dbg_gnt = 1'b1;
            else                    cpu_gnt = 1'b1;
          end else begin
            cpu_gnt = cpu_req;
            dbg_gnt = dbg_req;
          end
        end
        StLock:  dbg_gnt = dbg_req;
        default: ;
      endcase
    end
  end

  always_comb begin
    ptr_dbg_d = ptr_dbg_q;
    if (cpu_gnt)      ptr_dbg_d = 1'b1;
    else if (dbg_gnt) ptr_dbg_d = 1'b0;
  end

  always_comb begin
    mem_test_addr  = '0;
    mem_test_we    = 1'b0;
    mem_test_wdata = '0;
    if (cpu_gnt) begin
      mem_test_addr  = cpu_addr;
      mem_test_we    = cpu_we;
      mem_test_wdata = cpu_wdata;
    end else if (dbg_gnt) begin
      mem_test_addr  = dbg_addr;
      mem_test_we    = dbg_we;
      mem_test_wdata = dbg_wdata;
    end
  end

  // Read-return tags and per-port data hold registers
  always_ff @(posedge test_clk or negedge test_rst_n) begin
    if (!test_rst_n) begin
      ptr_dbg_q  <= 1'b0;
      cpu_rd_q   <= 1'b0;
      dbg_rd_q   <= 1'b0;
      cpu_hold_q <= '0;
      dbg_hold_q <= '0;
    end else begin
      ptr_dbg_q <= ptr_dbg_d;
      cpu_rd_q  <= cpu_gnt & ~cpu_we;
      dbg_rd_q  <= dbg_gnt & ~dbg_we;
      if (cpu_rd_q) cpu_hold_q <= mem_test_rdata;
      if (dbg_rd_q) dbg_hold_q <= mem_test_rdata;
    end
  end

  assign cpu_rvalid = cpu_rd_q;
  assign dbg_rvalid = dbg_rd_q;
  assign cpu_rdata  = cpu_rd_q ? mem_test_rdata : cpu_hold_q;
  assign dbg_rdata  = dbg_rd_q ? mem_test_rdata : dbg_hold_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter: a round-robin instance drives a registered-read RAM,
// a fixed-priority instance shares its inputs for grant comparison.
module tb_mem_arbiter;

  logic        test_clk;
  logic        test_rst_n;
  logic        cpu_req, cpu_we, dbg_req, dbg_we, dbg_lock;
  logic [14:0] cpu_addr, dbg_addr;
  logic [15:0] cpu_wdata, dbg_wdata;
  logic        cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid;
  logic [15:0] cpu_rdata, dbg_rdata;
  logic [14:0] mem_test_addr;
  logic        mem_test_we;
  logic [15:0] mem_test_wdata, mem_test_rdata;

  logic        fp_cpu_gnt, fp_cpu_rvalid, fp_dbg_gnt, fp_dbg_rvalid;
  logic [15:0] fp_cpu_rdata, fp_dbg_rdata, fp_mem_wdata;
  logic [14:0] fp_mem_addr;
  logic        fp_mem_we;

  logic        ram_load;
  logic [15:0] ram [0:32767];

  int n_pass = 0;
  int n_chk  = 0;

  mem_arbiter #(.RR_EN(1'b1)) dut (
    .test_clk(test_clk), .test_rst_n(test_rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_lock(dbg_lock), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_test_addr(mem_test_addr), .mem_test_we(mem_test_we),
    .mem_test_wdata(mem_test_wdata), .mem_test_rdata(mem_test_rdata)
  );

  mem_arbiter #(.RR_EN(1'b0)) dut_fp (
    .test_clk(test_clk), .test_rst_n(test_rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(fp_cpu_gnt), .cpu_rvalid(fp_cpu_rvalid), .cpu_rdata(fp_cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_lock(dbg_lock), .dbg_gnt(fp_dbg_gnt), .dbg_rvalid(fp_dbg_rvalid),
    .dbg_rdata(fp_dbg_rdata),
    .mem_test_addr(fp_mem_addr), .mem_test_we(fp_mem_we),
    .mem_test_wdata(fp_mem_wdata), .mem_test_rdata(mem_test_rdata)
  );

  initial test_clk = 1'b0;
  always #5 test_clk = ~test_clk;

  // Shared RAM: write at the access edge, registered read data one cycle later
  always @(posedge test_clk) begin
    if (ram_load) begin
      ram[9] <= 16'h0003;
    end else if (mem_test_we) begin
      ram[mem_test_addr] <= mem_test_wdata;
    end else begin
      mem_test_rdata <= ram[mem_test_addr];
    end
  end

  task automatic drive(input logic cr, input logic cw, input logic [14:0] ca,
                       input logic [15:0] cd, input logic dr, input logic dw,
                       input logic [14:0] da, input logic [15:0] dd, input logic dl);
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    dbg_req = dr; dbg_we = dw; dbg_addr = da; dbg_wdata = dd; dbg_lock = dl;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 15'd0, 16'h0, 1'b0, 1'b0, 15'd0, 16'h0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge test_clk);
    idle();
    test_rst_n = 1'b0;
    @(negedge test_clk);
    test_rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge test_clk);
    test_rst_n = 1'b0;
    ram_load   = 1'b1;
    drive(1'b1, 1'b1, 15'd5, 16'hffff, 1'b1, 1'b1, 15'd6, 16'hffff, 1'b0);
    #1;
    n_chk++; if (cpu_gnt !== 1'b0) $display("FAIL reset cpu_gnt: got %b want 0", cpu_gnt);
    else n_pass++;
    n_chk++; if (dbg_gnt !== 1'b0) $display("FAIL reset dbg_gnt: got %b want 0", dbg_gnt);
    else n_pass++;
    n_chk++; if (mem_test_we !== 1'b0) $display("FAIL reset mem_we: got %b want 0", mem_test_we);
    else n_pass++;
    n_chk++; if (cpu_rvalid !== 1'b0 || dbg_rvalid !== 1'b0)
      $display("FAIL reset rvalid: got %b%b want 00", cpu_rvalid, dbg_rvalid);
    else n_pass++;
    n_chk++; if (cpu_rdata !== 16'h0 || dbg_rdata !== 16'h0)
      $display("FAIL reset rdata: got %h/%h want 0000/0000", cpu_rdata, dbg_rdata);
    else n_pass++;
    @(negedge test_clk);
    idle();
    ram_load   = 1'b0;
    test_rst_n = 1'b1;
  endtask

  task automatic test_cpu_read();
    do_reset();
    @(negedge test_clk);
    drive(1'b1, 1'b0, 15'd9, 16'h0, 1'b0, 1'b0, 15'd0, 16'h0, 1'b0);
    #1;
    n_chk++; if (cpu_gnt !== 1'b1 || dbg_gnt !== 1'b0)
      $display("FAIL cpu_read gnt: got %b%b want 10", cpu_gnt, dbg_gnt);
    else n_pass++;
    n_chk++; if (mem_test_addr !== 15'd9 || mem_test_we !== 1'b0)
      $display("FAIL cpu_read mem: got addr %0d we %b want 9/0", mem_test_addr, mem_test_we);
    else n_pass++;
    @(negedge test_clk);
    idle();
    #1;
    n_chk++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 16'h0003)
      $display("FAIL cpu_read rvalid: got %b/%h want 1/0003", cpu_rvalid, cpu_rdata);
    else n_pass++;
    n_chk++; if (dbg_rvalid !== 1'b0) $display("FAIL cpu_read dbg_rvalid: got %b want 0", dbg_rvalid);
    else n_pass++;
    n_chk++; if (mem_test_addr !== 15'd0 || mem_test_wdata !== 16'h0)
      $display("FAIL idle mem: got %0d/%h want 0/0000", mem_test_addr, mem_test_wdata);
    else n_pass++;
    @(negedge test_clk);
    #1;
    n_chk++; if (cpu_rvalid !== 1'b0 || cpu_rdata !== 16'h0003)
      $display("FAIL cpu_read hold: got %b/%h want 0/0003", cpu_rvalid, cpu_rdata);
    else n_pass++;
  endtask

  task automatic test_lock();
    do_reset();
    // Tie after reset goes to CPU; the next tie goes to debug, which then locks
    @(negedge test_clk);
    drive(1'b1, 1'b0, 15'd16, 16'h0, 1'b1, 1'b1, 15'd16, 16'h1234, 1'b1);
    #1;
    n_chk++; if (cpu_gnt !== 1'b1 || dbg_gnt !== 1'b0)
      $display("FAIL lock tie0 gnt: got %b%b want 10", cpu_gnt, dbg_gnt);
    else n_pass++;
    for (int k = 1; k <= 4; k++) begin
      @(negedge test_clk);
      #1;
      n_chk++; if (cpu_gnt !== 1'b0 || dbg_gnt !== 1'b1)
        $display("FAIL lock cyc%0d gnt: got %b%b want 01", k, cpu_gnt, dbg_gnt);
      else n_pass++;
      if (k == 1) begin
        n_chk++; if (mem_test_we !== 1'b1 || mem_test_addr !== 15'd16 || mem_test_wdata !== 16'h1234)
          $display("FAIL lock write mem: got %b/%0d/%h want 1/16/1234",
                   mem_test_we, mem_test_addr, mem_test_wdata);
        else n_pass++;
      end
    end
    @(negedge test_clk);
    drive(1'b1, 1'b0, 15'd16, 16'h0, 1'b0, 1'b0, 15'd0, 16'h0, 1'b0);
    #1;
    n_chk++; if (cpu_gnt !== 1'b0) $display("FAIL lock drop cpu_gnt: got %b want 0", cpu_gnt);
    else n_pass++;
    @(negedge test_clk);
    #1;
    n_chk++; if (cpu_gnt !== 1'b1) $display("FAIL lock exit cpu_gnt: got %b want 1", cpu_gnt);
    else n_pass++;
    @(negedge test_clk);
    idle();
    #1;
    n_chk++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 16'h1234)
      $display("FAIL lock readback: got %b/%h want 1/1234", cpu_rvalid, cpu_rdata);
    else n_pass++;
  endtask

  task automatic test_reset_in_flight();
    @(negedge test_clk);
    drive(1'b1, 1'b0, 15'd9, 16'h0, 1'b0, 1'b0, 15'd0, 16'h0, 1'b0);
    #1;
    n_chk++; if (cpu_gnt !== 1'b1) $display("FAIL flight cpu_gnt: got %b want 1", cpu_gnt);
    else n_pass++;
    @(negedge test_clk);
    idle();
    test_rst_n = 1'b0;
    #1;
    n_chk++; if (cpu_rvalid !== 1'b0 || cpu_rdata !== 16'h0000)
      $display("FAIL flight cpu discard: got %b/%h want 0/0000", cpu_rvalid, cpu_rdata);
    else n_pass++;
    @(negedge test_clk);
    test_rst_n = 1'b1;
    // Enter LOCK, put a debug read in flight, then reset
    drive(1'b0, 1'b0, 15'd0, 16'h0, 1'b1, 1'b1, 15'd21, 16'h0055, 1'b1);
    @(negedge test_clk);
    drive(1'b1, 1'b0, 15'd9, 16'h0, 1'b1, 1'b0, 15'd9, 16'h0, 1'b1);
    #1;
    n_chk++; if (cpu_gnt !== 1'b0 || dbg_gnt !== 1'b1)
      $display("FAIL flight lock gnt: got %b%b want 01", cpu_gnt, dbg_gnt);
    else n_pass++;
    @(negedge test_clk);
    test_rst_n = 1'b0;
    #1;
    n_chk++; if (dbg_rvalid !== 1'b0 || dbg_rdata !== 16'h0000)
      $display("FAIL flight dbg discard: got %b/%h want 0/0000", dbg_rvalid, dbg_rdata);
    else n_pass++;
    n_chk++; if (cpu_gnt !== 1'b0 || dbg_gnt !== 1'b0)
      $display("FAIL flight in-reset gnt: got %b%b want 00", cpu_gnt, dbg_gnt);
    else n_pass++;
    @(negedge test_clk);
    test_rst_n = 1'b1;
    #1;
    n_chk++; if (cpu_gnt !== 1'b1 || dbg_gnt !== 1'b0)
      $display("FAIL flight post-reset arb: got %b%b want 10", cpu_gnt, dbg_gnt);
    else n_pass++;
    @(negedge test_clk);
    idle();
  endtask

  task automatic test_round_robin();
    logic exp_cg, exp_cv, exp_dv;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      @(negedge test_clk);
      drive(1'b1, 1'b0, 15'd9, 16'h0, 1'b1, 1'b0, 15'd16, 16'h0, 1'b0);
      #1;
      exp_cg = (k % 2 == 0);
      exp_cv = (k % 2 == 1);
      exp_dv = (k == 2);
      n_chk++; if (cpu_gnt !== exp_cg || dbg_gnt !== !exp_cg)
        $display("FAIL rr cyc%0d gnt: got %b%b want %b%b", k, cpu_gnt, dbg_gnt, exp_cg, !exp_cg);
      else n_pass++;
      n_chk++; if (cpu_rvalid !== exp_cv || dbg_rvalid !== exp_dv)
        $display("FAIL rr cyc%0d rvalid: got %b%b want %b%b", k, cpu_rvalid, dbg_rvalid,
                 exp_cv, exp_dv);
      else n_pass++;
      n_chk++; if (fp_cpu_gnt !== 1'b1 || fp_dbg_gnt !== 1'b0)
        $display("FAIL fixed cyc%0d gnt: got %b%b want 10", k, fp_cpu_gnt, fp_dbg_gnt);
      else n_pass++;
      if (k == 1) begin
        n_chk++; if (cpu_rdata !== 16'h0003)
          $display("FAIL rr cpu_rdata: got %h want 0003", cpu_rdata);
        else n_pass++;
      end
    end
    @(negedge test_clk);
    idle();
    #1;
    n_chk++; if (dbg_rvalid !== 1'b1 || dbg_rdata !== 16'h1234 || cpu_rvalid !== 1'b0)
      $display("FAIL rr tail: got dbg %b/%h cpu %b want 1/1234 0", dbg_rvalid, dbg_rdata,
               cpu_rvalid);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    @(negedge test_clk);
    drive(1'b0, 1'b0, 15'd0, 16'h0, 1'b1, 1'b1, 15'd17, 16'hbeef, 1'b0);
    #1;
    n_chk++; if (dbg_gnt !== 1'b1 || mem_test_we !== 1'b1 || mem_test_addr !== 15'd17 ||
                 mem_test_wdata !== 16'hbeef)
      $display("FAIL b2b write0: got %b/%b/%0d/%h want 1/1/17/beef", dbg_gnt, mem_test_we,
               mem_test_addr, mem_test_wdata);
    else n_pass++;
    @(negedge test_clk);
    drive(1'b1, 1'b0, 15'd17, 16'h0, 1'b0, 1'b0, 15'd0, 16'h0, 1'b0);
    #1;
    n_chk++; if (cpu_gnt !== 1'b1 || dbg_rvalid !== 1'b0)
      $display("FAIL b2b read0: got gnt %b dbg_rvalid %b want 1/0", cpu_gnt, dbg_rvalid);
    else n_pass++;
    @(negedge test_clk);
    drive(1'b0, 1'b0, 15'd0, 16'h0, 1'b1, 1'b1, 15'd17, 16'hcafe, 1'b0);
    #1;
    n_chk++; if (dbg_gnt !== 1'b1 || cpu_rvalid !== 1'b1 || cpu_rdata !== 16'hbeef)
      $display("FAIL b2b return0: got gnt %b %b/%h want 1 1/beef", dbg_gnt, cpu_rvalid,
               cpu_rdata);
    else n_pass++;
    @(negedge test_clk);
    drive(1'b1, 1'b0, 15'd17, 16'h0, 1'b0, 1'b0, 15'd0, 16'h0, 1'b0);
    #1;
    n_chk++; if (cpu_gnt !== 1'b1 || cpu_rvalid !== 1'b0 || cpu_rdata !== 16'hbeef ||
                 dbg_rvalid !== 1'b0)
      $display("FAIL b2b read1: got %b %b/%h dbg %b want 1 0/beef 0", cpu_gnt, cpu_rvalid,
               cpu_rdata, dbg_rvalid);
    else n_pass++;
    @(negedge test_clk);
    idle();
    #1;
    n_chk++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 16'hcafe)
      $display("FAIL b2b return1: got %b/%h want 1/cafe", cpu_rvalid, cpu_rdata);
    else n_pass++;
    n_chk++; if (mem_test_addr !== 15'd0 || mem_test_we !== 1'b0 || mem_test_wdata !== 16'h0)
      $display("FAIL b2b idle mem: got %0d/%b/%h want 0/0/0000", mem_test_addr, mem_test_we,
               mem_test_wdata);
    else n_pass++;
  endtask

  initial begin
    test_rst_n = 1'b0;
    ram_load   = 1'b0;
    idle();
    repeat (2) @(posedge test_clk);
    test_reset();
    test_cpu_read();
    test_lock();
    test_reset_in_flight();
    test_round_robin();
    test_back_to_back();
    repeat (2) @(negedge test_clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
